muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters, width constants and op codes SHALL be the codebase globals: XLEN=32, REG_ADDR_W=5, HART_ID_W=1 (HART_NUM=2).
REQ-002 Op codes SHALL be 3 bits: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
REQ-003 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 muldiv_start  input  1  request; sampled only when not busy.
REQ-007 muldiv_op  input  3  operation code.
REQ-008 muldiv_a  input  XLEN  rs1 operand (dividend / multiplicand).
REQ-009 muldiv_b  input  XLEN  rs2 operand (divisor / multiplier).
REQ-010 muldiv_hart_id  input  HART_ID_W  issuing hart tag.
REQ-011 muldiv_rd  input  REG_ADDR_W  destination register tag.
REQ-012 muldiv_busy  output  1  unit occupied.
REQ-013 muldiv_done  output  1  one-cycle completion pulse.
REQ-014 muldiv_result  output  XLEN  result, valid while done=1.
REQ-015 muldiv_done_hart_id  output  HART_ID_W  hart tag of the completing operation.
REQ-016 muldiv_done_rd  output  REG_ADDR_W  rd tag of the completing operation.

Function
REQ-017 Request acceptance: start=1 and busy=0 at a rising edge SHALL accept the request.
REQ-018 Latched at acceptance: op, a, b, hart_id, rd.
REQ-019 Start while busy=1, including the done cycle, SHALL be ignored; latched state is unaffected.
REQ-020 States SHALL be IDLE -> RUN -> DONE -> IDLE.
REQ-021 busy=1 in RUN and DONE; busy=0 only in IDLE.
REQ-022 Accepting edge: IDLE -> RUN.
REQ-023 RUN performs 32 iterations, one bit per cycle: shift-add multiply, restoring divide on magnitudes.
REQ-024 RUN -> DONE at the 32nd iteration edge.
REQ-025 DONE -> IDLE on the next edge.
REQ-026 Latency SHALL be fixed for every op, including special cases: done is high in the 33rd cycle after the accepting edge.
REQ-027 done SHALL be high for exactly one cycle, with busy=1 in that cycle.
REQ-028 busy SHALL be 0 in the cycle after done, so a back-to-back start can be accepted at the next edge.
REQ-029 During done, done_hart_id and done_rd SHALL equal the tags latched at acceptance; result SHALL hold its value until the next done.
REQ-030 MUL = low XLEN bits of a*b.
REQ-031 MULH = high XLEN bits of signed(a)*signed(b).
REQ-032 MULHU = high XLEN bits of unsigned(a)*unsigned(b).
REQ-033 MULHSU = high XLEN bits of signed(a)*unsigned(b).
REQ-034 Signed multiply: magnitudes are multiplied and the 2*XLEN product is negated when the signs differ; MULHSU treats b as positive.
REQ-035 DIV/REM signed: quotient truncates toward zero; remainder takes the sign of the dividend.
REQ-036 DIVU/REMU SHALL be unsigned.
REQ-037 Divide by zero (b=0): DIV and DIVU give all-ones; REM and REMU give a.
REQ-038 Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
REQ-039 No exceptions SHALL be raised by any op.

Reset
REQ-040 rst_n=0 SHALL immediately force: state IDLE, busy=0, done=0, result=0, done_hart_id=0, done_rd=0, internal registers=0.
REQ-041 An operation in flight at reset SHALL be discarded, with no done pulse.
REQ-042 A start asserted during reset SHALL be ignored.
REQ-043 The first accepted start SHALL be at the first rising edge with rst_n=1.

Verification
REQ-044 MUL: a=0xFFFFFFFF, b=2, hart 0, rd 3 -> result 0xFFFFFFFE, tags 0/3, one-cycle done.
REQ-045 High multiplies: MULH 0x80000000*2 -> 0xFFFFFFFF.
REQ-046 High multiplies: MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-047 High multiplies: MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-048 Divide basic and overflow: DIV 7/3 -> 2; DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
REQ-049 Divide by zero, REM sign: DIV 1/0 -> 0xFFFFFFFF; REMU 0xFFFFFFFF/0 -> 0xFFFFFFFF; REM 0xFFFFFFFE/7 -> 0xFFFFFFFE (-2).
REQ-050 Busy-ignore: DIV 0xFF/3 (hart 0, rd 13), then MUL 0xAA*2 (hart 1, rd 14) started 3 cycles later -> single done: result 0x55, hart 0, rd 13.
REQ-051 Random: 1000 random ops, operands and tags versus a reference model.
REQ-052 Random checks per run: result, tags, done width of 1 cycle, busy=1 during done.
REQ-053 Reset mid-RUN -> busy=0, done=0 immediately; no stale done afterwards.

Source files
------------

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32-cycle RV32M multiply/divide unit with hart and rd tagging.
module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int HART_ID_W  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  muldiv_start,
    input  logic [2:0]            muldiv_op,
    input  logic [XLEN-1:0]       muldiv_a,
    input  logic [XLEN-1:0]       muldiv_b,
    input  logic [HART_ID_W-1:0]  muldiv_hart_id,
    input  logic [REG_ADDR_W-1:0] muldiv_rd,
    output logic                  muldiv_busy,
    output logic                  muldiv_done,
    output logic [XLEN-1:0]       muldiv_result,
    output logic [HART_ID_W-1:0]  muldiv_done_hart_id,
    output logic [REG_ADDR_W-1:0] muldiv_done_rd
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    logic [1:0]            state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic [HART_ID_W-1:0]  hart_q, hart_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]       hi_q, hi_d;
    logic [XLEN-1:0]       lo_q, lo_d;
    logic [XLEN-1:0]       dsr_q, dsr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  a_neg_q, a_neg_d;
    logic                  b_neg_q, b_neg_d;
    logic                  b_zero_q, b_zero_d;
    logic [XLEN-1:0]       result_q, result_d;

    logic                  a_signed, b_signed;
    logic                  a_neg_in, b_neg_in;
    logic [XLEN-1:0]       a_mag, b_mag;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (muldiv_op)
            OP_MULH, OP_DIV, OP_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            OP_MULHSU: a_signed = 1'b1;
            default:   ;
        endcase
    end

    assign a_neg_in = a_signed & muldiv_a[XLEN-1];
    assign b_neg_in = b_signed & muldiv_b[XLEN-1];
    assign a_mag    = a_neg_in ? -muldiv_a : muldiv_a;
    assign b_mag    = b_neg_in ? -muldiv_b : muldiv_b;

    // Multiply: {hi,lo} holds partial product and remaining multiplier bits, shifted right.
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi, mul_lo;

    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dsr_q} : {(XLEN+1){1'b0}});
    assign mul_hi  = mul_sum[XLEN:1];
    assign mul_lo  = {mul_sum[0], lo_q[XLEN-1:1]};

    // Divide: hi is the partial remainder, lo shifts the dividend out and quotient bits in.
    logic [XLEN:0]   div_shl;
    logic            div_ge;
    logic [XLEN-1:0] div_diff, div_hi, div_lo;

    assign div_shl  = {hi_q, lo_q[XLEN-1]};
    assign div_ge   = div_shl >= {1'b0, dsr_q};
    assign div_diff = div_shl[XLEN-1:0] - dsr_q;
    assign div_hi   = div_ge ? div_diff : div_shl[XLEN-1:0];
    assign div_lo   = {lo_q[XLEN-2:0], div_ge};

    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s;
    logic [XLEN-1:0]   final_res;

    assign prod   = {mul_hi, mul_lo};
    assign prod_s = (a_neg_q ^ b_neg_q) ? -prod : prod;
    // A zero divisor must yield all-ones regardless of dividend sign, so skip quotient negation.
    assign quo_s  = (a_neg_q ^ b_neg_q) && !b_zero_q ? -div_lo : div_lo;
    assign rem_s  = a_neg_q ? -div_hi : div_hi;

    always_comb begin
        final_res = prod_s[XLEN-1:0];
        case (op_q)
            OP_MUL:                       final_res = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              final_res = quo_s;
            OP_REM, OP_REMU:              final_res = rem_s;
            default:                      final_res = prod_s[XLEN-1:0];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        hart_d   = hart_q;
        rd_d     = rd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dsr_d    = dsr_q;
        cnt_d    = cnt_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        b_zero_d = b_zero_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (muldiv_start) begin
                    state_d  = S_RUN;
                    op_d     = muldiv_op;
                    hart_d   = muldiv_hart_id;
                    rd_d     = muldiv_rd;
                    a_neg_d  = a_neg_in;
                    b_neg_d  = b_neg_in;
                    b_zero_d = (muldiv_b == '0);
                    cnt_d    = '0;
                    hi_d     = '0;
                    if (muldiv_op[2]) begin
                        lo_d  = a_mag;
                        dsr_d = b_mag;
                    end else begin
                        lo_d  = b_mag;
                        dsr_d = a_mag;
                    end
                end
            end
            S_RUN: begin
                hi_d  = op_q[2] ? div_hi : mul_hi;
                lo_d  = op_q[2] ? div_lo : mul_lo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d  = S_DONE;
                    result_d = final_res;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            hart_q   <= '0;
            rd_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dsr_q    <= '0;
            cnt_q    <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            hart_q   <= hart_d;
            rd_q     <= rd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dsr_q    <= dsr_d;
            cnt_q    <= cnt_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            b_zero_q <= b_zero_d;
            result_q <= result_d;
        end
    end

    assign muldiv_busy         = (state_q != S_IDLE);
    assign muldiv_done         = (state_q == S_DONE);
    assign muldiv_result       = result_q;
    assign muldiv_done_hart_id = hart_q;
    assign muldiv_done_rd      = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit against an arithmetic model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        hart;
    logic [4:0]  rd;
    logic        busy, done;
    logic [31:0] result;
    logic        done_hart;
    logic [4:0]  done_rd;

    int errors = 0;
    int checks = 0;
    int n, dcount;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    logic        rh;
    logic [4:0]  rr;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .muldiv_start        (start),
        .muldiv_op           (op),
        .muldiv_a            (a),
        .muldiv_b            (b),
        .muldiv_hart_id      (hart),
        .muldiv_rd           (rd),
        .muldiv_busy         (busy),
        .muldiv_done         (done),
        .muldiv_result       (result),
        .muldiv_done_hart_id (done_hart),
        .muldiv_done_rd      (done_rd)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (op=%0d a=0x%08h b=0x%08h)",
                     tag, got, exp, op, a, b);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x,
                                              input logic [31:0] y);
        longint      sx, sy, ux, uy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        p  = '0;
        case (f)
            3'd0: begin p = ux * uy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
            3'd4: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                p = sx / sy;
                return p[31:0];
            end
            3'd5: return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 32'd0) return x;
                p = sx % sy;
                return p[31:0];
            end
            default: return (y == 32'd0) ? x : x % y;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge with the unit idle; returns at a negedge with the unit idle.
    task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                          input logic h, input logic [4:0] r, input logic [31:0] exp);
        int lat;
        op = f; a = x; b = y; hart = h; rd = r; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk("latency", 32'(lat), 32'd33);
        if (lat != 0) begin
            chk("result", result, exp);
            chk("done_hart", 32'(done_hart), 32'(h));
            chk("done_rd", 32'(done_rd), 32'(r));
            chk("busy_in_done", 32'(busy), 32'd1);
        end
        @(negedge clk);
        chk("done_width", 32'(done), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("result_hold", result, exp);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5; hart = 1'b1; rd = 5'd9;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_hart", 32'(done_hart), 32'd0);
        chk("rst_rd", 32'(done_rd), 32'd0);
        rst_n = 1'b1;
        run_op(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, 5'd3, 32'hFFFF_FFFE);

        run_op(3'd1, 32'h8000_0000, 32'd2, 1'b1, 5'd5, 32'hFFFF_FFFF);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd6, 32'hFFFF_FFFE);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd7, 32'hFFFF_FFFF);
        run_op(3'd4, 32'd7, 32'd3, 1'b0, 5'd8, 32'd2);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'd9, 32'h8000_0000);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 5'd10, 32'd0);
        run_op(3'd4, 32'd1, 32'd0, 1'b0, 5'd11, 32'hFFFF_FFFF);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd0, 1'b1, 5'd12, 32'hFFFF_FFFF);
        run_op(3'd5, 32'd1234, 32'd0, 1'b1, 5'd15, 32'hFFFF_FFFF);
        run_op(3'd7, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd16, 32'hFFFF_FFFF);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 1'b1, 5'd17, 32'hFFFF_FFF9);
        run_op(3'd6, 32'hFFFF_FFFE, 32'd7, 1'b0, 5'd18, 32'hFFFF_FFFE);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1, 5'd19, 32'hFFFF_FFFD);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, 5'd20, 32'hFFFF_FFFF);

        // Starts issued mid-run and in the done cycle must both be dropped.
        op = 3'd4; a = 32'hFF; b = 32'd3; hart = 1'b0; rd = 5'd13; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0; dcount = 0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (i == 3) begin
                chk("ign_busy_run", 32'(busy), 32'd1);
                op = 3'd0; a = 32'hAA; b = 32'd2; hart = 1'b1; rd = 5'd14; start = 1'b1;
            end
            if (i == 4) start = 1'b0;
            if (n != 0 && i == n + 1) begin
                start = 1'b0;
                chk("ign_busy_after", 32'(busy), 32'd0);
            end
            if (done === 1'b1) begin
                dcount++;
                if (n == 0) begin
                    n = i;
                    chk("ign_result", result, 32'h55);
                    chk("ign_hart", 32'(done_hart), 32'd0);
                    chk("ign_rd", 32'(done_rd), 32'd13);
                    op = 3'd0; a = 32'hAA; b = 32'd2; hart = 1'b1; rd = 5'd14; start = 1'b1;
                end
            end
        end
        chk("ign_latency", 32'(n), 32'd33);
        chk("ign_done_count", 32'(dcount), 32'd1);
        chk("ign_result_kept", result, 32'h55);

        for (int k = 0; k < 1000; k++) begin
            ro = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            rh = 1'($urandom_range(0, 1));
            rr = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            run_op(ro, ra, rb, rh, rr, ref_model(ro, ra, rb));
        end

        run_op(3'd0, 32'd3, 32'd5, 1'b1, 5'd21, 32'd15);
        op = 3'd4; a = 32'd100; b = 32'd7; hart = 1'b1; rd = 5'd22; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        start = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_hart", 32'(done_hart), 32'd0);
        chk("mid_rst_rd", 32'(done_rd), 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_start_ignored", 32'(busy), 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        chk("no_stale_done", 32'(dcount), 32'd0);
        chk("idle_after_rst", 32'(busy), 32'd0);
        run_op(3'd5, 32'd100, 32'd7, 1'b1, 5'd23, 32'd14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
